// File: rtl/membus_pkg.sv
// Shared constants and state encoding for the PDP-6 memory-bus bridge.
package membus_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned WORD_W  = 36;
  localparam int unsigned TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WACK,
    WWAIT,
    WR,
    REL
  } state_t;

endpackage

// File: rtl/membus_bridge.sv
// PDP-6 memory-bus cycle to single-beat memory master bridge.
// Runs read, write and read-modify-write cycles against a slave that may stall
// with waitrequest. Optional macro MEMBUS_BRIDGE_TIMEOUT_EN adds a stall
// counter that aborts a stuck access and raises o_nxm.
module membus_bridge #(
  parameter int unsigned ADDR_W = membus_pkg::ADDR_W,
  parameter int unsigned WORD_W = membus_pkg::WORD_W
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = membus_pkg::TIMEOUT
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rq_cyc,
  input  logic              i_rd_rq,
  input  logic              i_wr_rq,
  input  logic [ADDR_W-1:0] i_ma,
  input  logic [WORD_W-1:0] i_mb_in,
  input  logic              i_wr_rs,
  output logic              o_addr_ack,
  output logic              o_rd_rs,
  output logic [WORD_W-1:0] o_mb_out,
  output logic              o_busy,
  output logic              o_nxm,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_read,
  output logic              o_write,
  output logic [WORD_W-1:0] o_writedata,
  input  logic [WORD_W-1:0] i_readdata,
  input  logic              i_waitrequest
);

  import membus_pkg::*;

  state_t              state, state_d;
  logic                wr_flag, wr_flag_d;
  logic [ADDR_W-1:0]   address_d;
  logic [WORD_W-1:0]   mb_out_d, writedata_d;
  logic                read_d, write_d, addr_ack_d, rd_rs_d;

`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             nxm, nxm_d;
  assign o_nxm = nxm;
`else
  assign o_nxm = 1'b0;
`endif

  // Next-state and next-output logic; strobe low inside RD marks the ack phase.
  always_comb begin
    state_d     = state;
    wr_flag_d   = wr_flag;
    address_d   = o_address;
    mb_out_d    = o_mb_out;
    writedata_d = o_writedata;
    read_d      = o_read;
    write_d     = o_write;
    addr_ack_d  = 1'b0;
    rd_rs_d     = 1'b0;
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt;
    nxm_d       = nxm;
`endif
    case (state)
      IDLE: begin
        if (i_rq_cyc && (i_rd_rq || i_wr_rq)) begin
          address_d = i_ma;
          wr_flag_d = i_wr_rq;
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
          nxm_d     = 1'b0;
`endif
          if (i_rd_rq) begin
            state_d = RD;
            read_d  = 1'b1;
          end else begin
            state_d    = WACK;
            addr_ack_d = 1'b1;
          end
        end
      end
      RD: begin
        if (o_read) begin
          if (!i_waitrequest) begin
            mb_out_d = i_readdata;
            read_d   = 1'b0;
          end
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            read_d  = 1'b0;
            nxm_d   = 1'b1;
            state_d = REL;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
`endif
        end else begin
          addr_ack_d = 1'b1;
          rd_rs_d    = 1'b1;
          state_d    = wr_flag ? WWAIT : REL;
        end
      end
      WACK: begin
        state_d = WWAIT;
      end
      WWAIT: begin
        // Write restart wins over a simultaneous drop of the request.
        if (i_wr_rs) begin
          writedata_d = i_mb_in;
          write_d     = 1'b1;
          state_d     = WR;
        end else if (!i_rq_cyc) begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (!i_waitrequest) begin
          write_d = 1'b0;
          state_d = REL;
        end
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          write_d = 1'b0;
          nxm_d   = 1'b1;
          state_d = REL;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      REL: begin
        if (!i_rq_cyc) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
    if (state_d != state) cnt_d = '0;
`endif
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      wr_flag     <= 1'b0;
      o_address   <= '0;
      o_mb_out    <= '0;
      o_writedata <= '0;
      o_read      <= 1'b0;
      o_write     <= 1'b0;
      o_addr_ack  <= 1'b0;
      o_rd_rs     <= 1'b0;
      o_busy      <= 1'b0;
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
      cnt         <= '0;
      nxm         <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      wr_flag     <= wr_flag_d;
      o_address   <= address_d;
      o_mb_out    <= mb_out_d;
      o_writedata <= writedata_d;
      o_read      <= read_d;
      o_write     <= write_d;
      o_addr_ack  <= addr_ack_d;
      o_rd_rs     <= rd_rs_d;
      o_busy      <= (state_d != IDLE);
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
      cnt         <= cnt_d;
      nxm         <= nxm_d;
`endif
    end
  end

endmodule

// File: tb/tb_membus_bridge.sv
// Directed bench for membus_bridge with a behavioural memory slave whose
// stall length is programmable per test.
module tb_membus_bridge;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_rq_cyc, i_rd_rq, i_wr_rq, i_wr_rs;
  logic [17:0] i_ma;
  logic [35:0] i_mb_in;
  logic        o_addr_ack, o_rd_rs, o_busy, o_nxm, o_read, o_write;
  logic [35:0] o_mb_out, o_writedata;
  logic [17:0] o_address;
  logic [35:0] i_readdata;
  logic        i_waitrequest;

  int checks = 0;
  int failures = 0;

  // memory slave model
  logic [35:0] mem [0:511];
  int          wait_n = 0;
  int          wcnt = 0;
  int          reads_done = 0;
  int          writes_done = 0;
  int          overlap = 0;
  logic        poke_en = 1'b0;
  logic [8:0]  poke_addr = '0;
  logic [35:0] poke_data = '0;

  always #5 clk = ~clk;

  membus_bridge dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rq_cyc     (i_rq_cyc),
    .i_rd_rq      (i_rd_rq),
    .i_wr_rq      (i_wr_rq),
    .i_ma         (i_ma),
    .i_mb_in      (i_mb_in),
    .i_wr_rs      (i_wr_rs),
    .o_addr_ack   (o_addr_ack),
    .o_rd_rs      (o_rd_rs),
    .o_mb_out     (o_mb_out),
    .o_busy       (o_busy),
    .o_nxm        (o_nxm),
    .o_address    (o_address),
    .o_read       (o_read),
    .o_write      (o_write),
    .o_writedata  (o_writedata),
    .i_readdata   (i_readdata),
    .i_waitrequest(i_waitrequest)
  );

  assign i_waitrequest = (o_read || o_write) && (wcnt < wait_n);
  assign i_readdata    = mem[o_address[8:0]];

  // Memory slave: stall counter, access bookkeeping, write port and preload port.
  always @(posedge clk) begin
    if (o_read && o_write) overlap <= overlap + 1;
    if (!(o_read || o_write)) wcnt <= 0;
    else if (i_waitrequest) wcnt <= wcnt + 1;
    if (o_read && !i_waitrequest) reads_done <= reads_done + 1;
    if (o_write && !i_waitrequest) begin
      mem[o_address[8:0]] <= o_writedata;
      writes_done <= writes_done + 1;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [8:0] a, input logic [35:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // Present a request; returns just after the sampling edge.
  task automatic start_cycle(input logic rd, input logic wr, input logic [17:0] ma);
    i_ma     = ma;
    i_rd_rq  = rd;
    i_wr_rq  = wr;
    i_rq_cyc = 1'b1;
    tick();
    i_ma    = 18'o0;
    i_rd_rq = 1'b0;
    i_wr_rq = 1'b0;
  endtask

  // Step until o_rd_rs; lat counts edges after the sampling edge (0 if never seen).
  task automatic wait_rd_rs(output int lat, output int rd_hi, output logic ack,
                            output logic addr_moved, input logic [17:0] ma);
    bit seen = 0;
    lat = 0;
    rd_hi = o_read ? 1 : 0;
    ack = 1'b0;
    addr_moved = (o_address !== ma);
    for (int k = 1; k <= 40 && !seen; k++) begin
      tick();
      if (o_read) rd_hi++;
      if (o_address !== ma) addr_moved = 1'b1;
      if (o_rd_rs) begin
        seen = 1;
        lat = k;
        ack = o_addr_ack;
      end
    end
  endtask

  task automatic release_cycle();
    i_rq_cyc = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_rq_cyc = 0; i_rd_rq = 0; i_wr_rq = 0; i_wr_rs = 0;
    i_ma = '0; i_mb_in = '0;
    #23;
    checks++;
    if ({o_addr_ack, o_rd_rs, o_mb_out, o_busy, o_nxm, o_address, o_read, o_write, o_writedata} !== 96'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b mb_out=%o addr=%o required all zero",
               o_busy, o_read, o_write, o_mb_out, o_address);
    end
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_nxm !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b nxm=%b required 0 0", o_busy, o_nxm);
    end
  endtask

  task automatic test_read_zero_wait();
    int lat, rd_hi; logic ack, moved;
    wait_n = 0;
    poke(9'o123, 36'o123456701234);
    start_cycle(1'b1, 1'b0, 18'o123);
    checks++;
    if (o_read !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL zw_strobe: got read=%b busy=%b required 1 1", o_read, o_busy);
    end
    wait_rd_rs(lat, rd_hi, ack, moved, 18'o123);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL zw_latency: got %0d required 2", lat);
    end
    checks++;
    if (ack !== 1'b1 || o_mb_out !== 36'o123456701234) begin
      failures++;
      $display("FAIL zw_data: got ack=%b mb_out=%o required 1 123456701234", ack, o_mb_out);
    end
    checks++;
    if (rd_hi !== 1 || moved !== 1'b0) begin
      failures++;
      $display("FAIL zw_strobe_len: got read_cycles=%0d addr_moved=%b required 1 0", rd_hi, moved);
    end
    tick();
    checks++;
    if (o_rd_rs !== 1'b0 || o_addr_ack !== 1'b0) begin
      failures++;
      $display("FAIL zw_pulse_width: got rd_rs=%b ack=%b required 0 0", o_rd_rs, o_addr_ack);
    end
    release_cycle();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL zw_release: got busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_read_delayed();
    int lat, rd_hi; logic ack, moved;
    wait_n = 4;
    poke(9'o124, 36'o701234567012);
    start_cycle(1'b1, 1'b0, 18'o124);
    wait_rd_rs(lat, rd_hi, ack, moved, 18'o124);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL dl_latency: got %0d required 6", lat);
    end
    checks++;
    if (rd_hi !== 5 || moved !== 1'b0) begin
      failures++;
      $display("FAIL dl_strobe_hold: got read_cycles=%0d addr_moved=%b required 5 0", rd_hi, moved);
    end
    checks++;
    if (o_mb_out !== 36'o701234567012) begin
      failures++;
      $display("FAIL dl_data: got %o required 701234567012", o_mb_out);
    end
    release_cycle();
  endtask

  task automatic test_rmw();
    int lat, rd_hi, wr_hi; logic ack, moved;
    wait_n = 2;
    poke(9'o40, 36'o111111222222);
    start_cycle(1'b1, 1'b1, 18'o40);
    wait_rd_rs(lat, rd_hi, ack, moved, 18'o40);
    checks++;
    if (lat !== 4 || o_mb_out !== 36'o111111222222) begin
      failures++;
      $display("FAIL rmw_read: got lat=%0d mb_out=%o required 4 111111222222", lat, o_mb_out);
    end
    i_mb_in = 36'o777777000000;
    i_wr_rs = 1'b1;
    tick();
    i_wr_rs = 1'b0;
    checks++;
    if (o_write !== 1'b1 || o_writedata !== 36'o777777000000) begin
      failures++;
      $display("FAIL rmw_write_start: got write=%b data=%o required 1 777777000000", o_write, o_writedata);
    end
    checks++;
    if (mem[9'o40] !== 36'o111111222222) begin
      failures++;
      $display("FAIL rmw_mem_early: got %o required 111111222222", mem[9'o40]);
    end
    wr_hi = 1;
    for (int k = 0; k < 20 && o_write; k++) begin
      tick();
      if (o_write) wr_hi++;
    end
    checks++;
    if (wr_hi !== 3 || mem[9'o40] !== 36'o777777000000) begin
      failures++;
      $display("FAIL rmw_mem_update: got write_cycles=%0d mem=%o required 3 777777000000", wr_hi, mem[9'o40]);
    end
    checks++;
    if (overlap !== 0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmw_overlap_rel: got overlap=%0d busy=%b required 0 1", overlap, o_busy);
    end
    release_cycle();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL rmw_release: got busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_write_abort();
    int acks, rss, wrs, wd_before;
    wait_n = 0;
    poke(9'o55, 36'o555555555555);
    wd_before = writes_done;
    start_cycle(1'b0, 1'b1, 18'o55);
    acks = o_addr_ack ? 1 : 0;
    rss = o_rd_rs ? 1 : 0;
    wrs = o_write ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_addr_ack) acks++;
      if (o_rd_rs) rss++;
      if (o_write) wrs++;
    end
    i_rq_cyc = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL wa_idle: got busy=%b required 0", o_busy);
    end
    i_mb_in = 36'o0;
    i_wr_rs = 1'b1;
    tick();
    i_wr_rs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (o_write || o_busy) wrs++;
      tick();
    end
    checks++;
    if (acks !== 1 || rss !== 0) begin
      failures++;
      $display("FAIL wa_pulses: got ack=%0d rd_rs=%0d required 1 0", acks, rss);
    end
    checks++;
    if (wrs !== 0 || writes_done !== wd_before || mem[9'o55] !== 36'o555555555555) begin
      failures++;
      $display("FAIL wa_no_write: got write_cycles=%0d writes=%0d mem=%o required 0 %0d 555555555555",
               wrs, writes_done, mem[9'o55], wd_before);
    end
  endtask

  task automatic test_same_edge();
    wait_n = 0;
    poke(9'o70, 36'o0);
    start_cycle(1'b0, 1'b1, 18'o70);
    tick();
    i_mb_in  = 36'o252525252525;
    i_wr_rs  = 1'b1;
    i_rq_cyc = 1'b0;
    tick();
    i_wr_rs = 1'b0;
    checks++;
    if (o_write !== 1'b1) begin
      failures++;
      $display("FAIL se_write: got write=%b required 1", o_write);
    end
    tick();
    tick();
    checks++;
    if (mem[9'o70] !== 36'o252525252525 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL se_done: got mem=%o busy=%b required 252525252525 0", mem[9'o70], o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int r_before, pulses;
    wait_n = 0;
    r_before = reads_done;
    start_cycle(1'b1, 1'b0, 18'o123);
    pulses = 0;
    i_rd_rq = 1'b1;
    i_ma = 18'o124;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_rd_rs) pulses++;
    end
    i_rd_rq = 1'b0;
    checks++;
    if (reads_done - r_before !== 1 || pulses !== 1) begin
      failures++;
      $display("FAIL held_single: got reads=%0d pulses=%0d required 1 1", reads_done - r_before, pulses);
    end
    checks++;
    if (o_busy !== 1'b1 || o_address !== 18'o123) begin
      failures++;
      $display("FAIL held_rel: got busy=%b addr=%o required 1 123", o_busy, o_address);
    end
    release_cycle();
  endtask

  task automatic test_reset_in_write();
    wait_n = 100;
    poke(9'o60, 36'o606060606060);
    start_cycle(1'b0, 1'b1, 18'o60);
    tick();
    i_mb_in = 36'o1;
    i_wr_rs = 1'b1;
    tick();
    i_wr_rs = 1'b0;
    checks++;
    if (o_write !== 1'b1) begin
      failures++;
      $display("FAIL rw_write_on: got %b required 1", o_write);
    end
    tick();
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_addr_ack, o_rd_rs, o_mb_out, o_busy, o_nxm, o_address, o_read, o_write, o_writedata} !== 96'd0) begin
      failures++;
      $display("FAIL rw_reset_outputs: got write=%b busy=%b addr=%o wdata=%o required all zero",
               o_write, o_busy, o_address, o_writedata);
    end
    @(posedge clk);
    #1;
    i_rq_cyc = 1'b0;
    i_reset  = 1'b0;
    wait_n   = 0;
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_write !== 1'b0 || mem[9'o60] !== 36'o606060606060) begin
      failures++;
      $display("FAIL rw_after_reset: got busy=%b write=%b mem=%o required 0 0 606060606060",
               o_busy, o_write, mem[9'o60]);
    end
  endtask

`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int rd_hi, rss, acks, lat, rh; logic ack, moved;
    wait_n = 1000;
    start_cycle(1'b1, 1'b0, 18'o10);
    rd_hi = o_read ? 1 : 0;
    rss = 0;
    acks = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_read) rd_hi++;
      if (o_rd_rs) rss++;
      if (o_addr_ack) acks++;
    end
    checks++;
    if (rd_hi !== 16 || o_nxm !== 1'b1) begin
      failures++;
      $display("FAIL to_abort: got read_cycles=%0d nxm=%b required 16 1", rd_hi, o_nxm);
    end
    checks++;
    if (rss !== 0 || acks !== 0) begin
      failures++;
      $display("FAIL to_no_pulses: got rd_rs=%0d ack=%0d required 0 0", rss, acks);
    end
    release_cycle();
    checks++;
    if (o_nxm !== 1'b1) begin
      failures++;
      $display("FAIL to_nxm_hold: got %b required 1", o_nxm);
    end
    wait_n = 0;
    start_cycle(1'b1, 1'b0, 18'o123);
    checks++;
    if (o_nxm !== 1'b0) begin
      failures++;
      $display("FAIL to_nxm_clear: got %b required 0", o_nxm);
    end
    wait_rd_rs(lat, rh, ack, moved, 18'o123);
    release_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_read_delayed();
    test_rmw();
    test_write_abort();
    test_same_edge();
    test_back_to_back();
    test_reset_in_write();
`ifdef MEMBUS_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
